// File: rtl/ifetch_axi_master.sv
// Instruction-fetch front end: single-beat AXI4 reads from dram_base + pc,
// a small instruction buffer toward decode, redirect and stop-on-fault.
module ifetch_axi_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [2:0]  ARPROT_VAL = 3'b100
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        run,
  input  logic [31:0] dram_base,
  input  logic [31:0] entry_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [2:0]  m_arprot,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_bits,
  output logic        inst_fault,
  output logic [31:0] debug_last_pc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] bits;
    logic            fault;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HALT} state_t;

  state_t          state, state_n;
  logic            run_q;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pc_req, pc_req_n;
  logic            discard, discard_n;
  logic [XLEN-1:0] araddr_n;
  logic            arvalid_n, rready_n;

  entry_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, rd_n, wr_ptr, wr_n;
  logic [CNT_W-1:0] count, count_n;
  entry_t          head_n;
  entry_t          push_entry;
  logic            valid_n;

  logic rise, flush, ar_hs, r_hs, pop, push, outstanding, issue;

  // Single-beat, incrementing, word-sized reads with fixed protection.
  assign m_arlen   = 8'd0;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_arprot  = ARPROT_VAL;

  // Every read is a single beat, so RLAST carries no information.
  logic unused_rlast;
  assign unused_rlast = m_rlast;

  // Handshake and flush qualifiers shared by the control and buffer logic.
  assign rise  = run & ~run_q;
  assign flush = redirect_valid | rise | ~run;
  assign ar_hs = m_arvalid & m_arready;
  assign r_hs  = m_rvalid & m_rready;
  assign pop   = inst_valid & inst_ready & ~flush;

  assign push_entry.pc    = pc_req;
  assign push_entry.bits  = m_rdata;
  assign push_entry.fault = |m_rresp;

  // Next-state, pc bookkeeping, buffer pointers and AR issue decision.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pc_req_n    = pc_req;
    discard_n   = discard;
    araddr_n    = m_araddr;
    push        = 1'b0;
    outstanding = 1'b0;
    issue       = 1'b0;

    case (state)
      ADDR: begin
        outstanding = 1'b1;
        if (ar_hs) state_n = DATA;
      end
      DATA: begin
        if (r_hs) begin
          state_n   = IDLE;
          discard_n = 1'b0;
          if (!discard && !flush) begin
            push = 1'b1;
            pc_n = pc_req + 32'd4;
            if (push_entry.fault) state_n = HALT;
          end
        end else begin
          outstanding = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid || !run) state_n = IDLE;
      end
      default: ;
    endcase

    if (rise)           pc_n = entry_pc;
    if (redirect_valid) pc_n = redirect_pc;
    // A read already in flight belongs to the old stream; drop its data.
    if ((rise || redirect_valid) && outstanding) discard_n = 1'b1;

    rd_n    = flush ? '0 : rd_ptr + PTR_W'(pop);
    wr_n    = flush ? '0 : wr_ptr + PTR_W'(push);
    count_n = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    head_n  = (push && (wr_ptr == rd_n)) ? push_entry : mem[rd_n];
    valid_n = (count_n != '0);

    // One read in flight at most, and only when its data has a slot.
    if (state_n == IDLE && run && !rise && (count_n < CNT_W'(FIFO_DEPTH))) begin
      issue    = 1'b1;
      state_n  = ADDR;
      pc_req_n = pc_n;
      araddr_n = dram_base + pc_n;
    end

    arvalid_n = (state_n == ADDR);
    rready_n  = (state_n == DATA);
  end

  // Control state, pc and AXI request registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      run_q     <= 1'b0;
      pc        <= '0;
      pc_req    <= '0;
      discard   <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      state     <= state_n;
      run_q     <= run;
      pc        <= pc_n;
      pc_req    <= pc_req_n;
      discard   <= discard_n;
      m_araddr  <= araddr_n;
      m_arvalid <= arvalid_n;
      m_rready  <= rready_n;
    end
  end

  // Instruction buffer storage; contents are qualified by the pointers.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Buffer pointers, registered head toward decode and debug pc.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      inst_valid    <= 1'b0;
      inst_pc       <= '0;
      inst_bits     <= '0;
      inst_fault    <= 1'b0;
      debug_last_pc <= '0;
    end else begin
      rd_ptr     <= rd_n;
      wr_ptr     <= wr_n;
      count      <= count_n;
      inst_valid <= valid_n;
      inst_pc    <= head_n.pc;
      inst_bits  <= head_n.bits;
      inst_fault <= head_n.fault;
      if (pop) debug_last_pc <= inst_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_axi_master.sv
// Self-checking bench for ifetch_axi_master: randomized AXI slave plus a
// transaction-level model of the expected address and instruction streams.
module tb_ifetch_axi_master;

  localparam int unsigned DEPTH = 4;

  logic        ACLK, ARESETN;
  logic        run;
  logic [31:0] dram_base, entry_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] m_araddr;
  logic        m_arvalid, m_arready;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [2:0]  m_arprot;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_pc, inst_bits;
  logic        inst_fault;
  logic [31:0] debug_last_pc;

  ifetch_axi_master #(.FIFO_DEPTH(DEPTH), .ARPROT_VAL(3'b100)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .run(run),
    .dram_base(dram_base), .entry_pc(entry_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arprot(m_arprot), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
    .inst_bits(inst_bits), .inst_fault(inst_fault),
    .debug_last_pc(debug_last_pc)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    int          delay;
    bit          drop;
  } rtx_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // stimulus configuration
  bit          run_cfg;
  int          rdy_mode;
  int          ar_max, r_min, r_max;
  bit          redir_req;
  logic [31:0] redir_tgt;
  bit          fault_en;
  logic [31:0] fault_pc;

  // model state
  int          m_count;
  logic [31:0] m_last;
  bit          m_halt;
  logic [31:0] exp_pc, ar_exp_pc;
  bit          stale_ar;
  bit          prev_ar_pend;
  logic [31:0] prev_addr;
  int          ar_wait;
  int          run_cyc, first_ar_cyc;
  rtx_t        pend[$];
  logic [31:0] ar_log[$];
  logic [31:0] inst_log[$];
  bit          pop_fault[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_count = 0; m_last = '0; m_halt = 0; stale_ar = 0;
    prev_ar_pend = 0; prev_addr = '0; ar_wait = -1;
    first_ar_cyc = -1; run_cyc = -1;
    pend.delete(); ar_log.delete(); inst_log.delete(); pop_fault.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_arvalid", 32'(m_arvalid), 32'd0);
    check("rst_rready", 32'(m_rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_debug_last_pc", debug_last_pc, 32'd0);
    check("rst_araddr", m_araddr, 32'd0);
  endtask

  // One clock: check outputs against the model, drive inputs, then account
  // for the handshakes that the coming edge will complete.
  task automatic step();
    bit   ar_hs, r_hs, pp;
    rtx_t e;
    @(posedge ACLK); #1;
    cyc++;

    check("debug_last_pc", debug_last_pc, m_last);
    check("inst_valid", 32'(inst_valid), 32'(m_count != 0));
    if (inst_valid) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_bits", inst_bits, word_at(dram_base + exp_pc));
      check("inst_fault", 32'(inst_fault), 32'(fault_en && (exp_pc == fault_pc)));
    end
    if (prev_ar_pend) begin
      check("arvalid_hold", 32'(m_arvalid), 32'd1);
      check("araddr_hold", m_araddr, prev_addr);
    end
    if (m_halt) check("halt_no_ar", 32'(m_arvalid), 32'd0);
    if (m_arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;

    if (run_cfg && !run) run_cyc = cyc;
    run            = run_cfg;
    redirect_valid = redir_req;
    redirect_pc    = redir_tgt;
    redir_req      = 1'b0;
    case (rdy_mode)
      0:       inst_ready = 1'b0;
      1:       inst_ready = 1'b1;
      default: inst_ready = ($urandom_range(0, 3) != 0);
    endcase

    if (m_arvalid) begin
      if (ar_wait < 0) ar_wait = $urandom_range(0, ar_max);
      m_arready = (ar_wait == 0);
      if (ar_wait > 0) ar_wait--;
    end else begin
      m_arready = 1'b0;
    end

    if (pend.size() > 0 && pend[0].delay == 0) begin
      m_rvalid = 1'b1;
      m_rdata  = word_at(pend[0].addr);
      m_rresp  = (fault_en && pend[0].addr == dram_base + fault_pc) ? 2'b10 : 2'b00;
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom_range(0, 3));
      if (pend.size() > 0) begin
        e = pend[0]; e.delay--; pend[0] = e;
      end
    end
    m_rlast = m_rvalid;

    ar_hs = m_arvalid && m_arready;
    r_hs  = m_rvalid && m_rready;
    pp    = inst_valid && inst_ready;

    if (ar_hs) begin
      check("one_outstanding", 32'(pend.size()), 32'd0);
      check("fifo_room", 32'(m_count < DEPTH), 32'd1);
      e.addr  = m_araddr;
      e.delay = $urandom_range(r_min, r_max);
      e.drop  = stale_ar;
      if (!stale_ar) begin
        check("araddr", m_araddr, dram_base + ar_exp_pc);
        ar_exp_pc = ar_exp_pc + 32'd4;
      end
      stale_ar = 0;
      pend.push_back(e);
      ar_log.push_back(m_araddr);
      ar_wait = -1;
    end

    if (r_hs && pend.size() > 0) begin
      e = pend.pop_front();
      if (!e.drop && !redirect_valid) begin
        m_count++;
        if (m_rresp != 2'b00) m_halt = 1;
      end
    end

    if (pp && !redirect_valid) begin
      m_count--;
      m_last = exp_pc;
      inst_log.push_back(exp_pc);
      pop_fault.push_back(inst_fault);
      exp_pc = exp_pc + 32'd4;
    end

    if (redirect_valid) begin
      m_count   = 0;
      m_halt    = 0;
      exp_pc    = redirect_pc;
      ar_exp_pc = redirect_pc;
      foreach (pend[i]) begin
        e = pend[i]; e.drop = 1; pend[i] = e;
      end
      if (m_arvalid && !ar_hs) stale_ar = 1;
    end

    prev_ar_pend = m_arvalid && !ar_hs;
    prev_addr    = m_araddr;
  endtask

  task automatic reset_phase(input logic [31:0] base, input logic [31:0] entry);
    ARESETN = 1'b0;
    run_cfg = 0;
    #1;
    model_clear();
    dram_base = base;
    entry_pc  = entry;
    exp_pc    = entry;
    ar_exp_pc = entry;
    step();
    check_reset_outputs();
    ARESETN = 1'b1;
    step();
    step();
    run_cfg = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, iidx;
    bit found;
    ARESETN = 1'b0; run = 1'b0; dram_base = '0; entry_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0; m_arready = 1'b0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0; inst_ready = 1'b0;
    run_cfg = 0; rdy_mode = 1; ar_max = 0; r_min = 0; r_max = 0;
    redir_req = 0; redir_tgt = '0; fault_en = 0; fault_pc = '0;
    model_clear();

    // streaming with zero-wait slave
    reset_phase(32'h2000_0000, 32'h0);
    for (int i = 0; i < 30; i++) step();
    check("run_to_arvalid", 32'(first_ar_cyc - run_cyc), 32'd2);
    check("ar0", ar_log[0], 32'h2000_0000);
    check("ar1", ar_log[1], 32'h2000_0004);
    check("ar2", ar_log[2], 32'h2000_0008);
    check("pc0", inst_log[0], 32'h0);
    check("pc1", inst_log[1], 32'h4);
    check("pc2", inst_log[2], 32'h8);

    // random slave and consumer delays, 64 words
    ar_max = 7; r_min = 0; r_max = 7; rdy_mode = 2;
    reset_phase({$urandom} & 32'hFFFF_FFFC, 32'h40);
    for (int i = 0; i < 3000 && inst_log.size() < 64; i++) step();
    check("stream_64_words", 32'(inst_log.size() >= 64), 32'd1);

    // random redirects under random delays
    reset_phase(32'h1000_0000, 32'h0);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        redir_req = 1;
        redir_tgt = {$urandom} & 32'hFFFF_FFFC;
      end
      step();
    end

    // consumer stalled: buffer fills, then resumes
    ar_max = 0; r_min = 0; r_max = 0; rdy_mode = 0;
    reset_phase(32'h2000_0000, 32'h0);
    for (int i = 0; i < 40; i++) step();
    check("stall_reads", 32'(ar_log.size()), 32'd4);
    check("stall_arvalid", 32'(m_arvalid), 32'd0);
    rdy_mode = 1;
    for (int i = 0; i < 50 && ar_log.size() < 5; i++) step();
    check("resume_addr", ar_log[4], 32'h2000_0010);
    for (int i = 0; i < 10; i++) step();

    // redirect while data for pc 0x8 is pending
    r_min = 3; r_max = 3;
    reset_phase(32'h2000_0000, 32'h0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_rready && pend.size() > 0 && pend[0].addr == 32'h2000_0008) found = 1;
    end
    check("reached_data_pc8", 32'(found), 32'd1);
    idx = ar_log.size(); iidx = inst_log.size();
    redir_req = 1; redir_tgt = 32'h100;
    step();
    step();
    check("redirect_flush", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 100 && inst_log.size() <= iidx; i++) step();
    check("redirect_addr", ar_log[idx], 32'h2000_0100);
    check("redirect_first_pc", inst_log[iidx], 32'h100);

    // bus error at pc 0xC halts fetch until redirect
    r_min = 0; r_max = 0; fault_en = 1; fault_pc = 32'hC;
    reset_phase(32'h2000_0000, 32'h0);
    for (int i = 0; i < 60; i++) step();
    check("fault_delivered", 32'(inst_log.size()), 32'd4);
    check("fault_pc", inst_log[3], 32'hC);
    check("fault_flag", 32'(pop_fault[3]), 32'd1);
    check("fault_reads", 32'(ar_log.size()), 32'd4);
    fault_en = 0;
    idx = ar_log.size();
    redir_req = 1; redir_tgt = 32'h0;
    for (int i = 0; i < 50 && ar_log.size() <= idx; i++) step();
    check("fault_restart_addr", ar_log[idx], 32'h2000_0000);
    for (int i = 0; i < 10; i++) step();

    // asynchronous reset while a read is in flight
    r_min = 4; r_max = 4;
    reset_phase(32'h2000_0000, 32'h0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = m_rready;
    end
    check("reached_data", 32'(found), 32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check_reset_outputs();

    // pc wraps past 0xFFFF_FFFC
    r_min = 0; r_max = 0;
    reset_phase(32'h2000_0000, 32'hFFFF_FFFC);
    for (int i = 0; i < 40; i++) step();
    check("wrap_ar0", ar_log[0], 32'h1FFF_FFFC);
    check("wrap_ar1", ar_log[1], 32'h2000_0000);
    check("wrap_pc1", inst_log[1], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_axi_master.md
Name: ifetch_axi_master

Overview:
- Instruction-fetch front end between the boot controller and the core decode stage.
- On `run`, it fetches 32-bit words over an AXI4 read master from physical address `dram_base + pc`.
- Fetched words are buffered in a small FIFO and presented to decode with their PC.
- It also exports the last consumed PC on the DEBUG bus.
- Supports redirects (branches/traps) and stop-on-fault.

Parameters:
- FIFO_DEPTH, 4, instruction buffer entries (power of two, >= 2).
- ARPROT_VAL, 3'b100, constant ARPROT value (instruction, secure, unprivileged).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- run  in  1  fetch enable (level, from boot controller)
- dram_base  in  32  physical base added to every PC
- entry_pc  in  32  PC loaded on run rising edge
- redirect_valid  in  1  one-cycle redirect request
- redirect_pc  in  32  new PC for redirect
- m_araddr  out  32  AXI read address
- m_arvalid  out  1  AXI AR valid
- m_arready  in  1  AXI AR ready
- m_arlen  out  8  constant 0 (single beat)
- m_arsize  out  3  constant 3'b010
- m_arburst  out  2  constant 2'b01
- m_arprot  out  3  ARPROT_VAL
- m_rdata  in  32  AXI read data
- m_rresp  in  2  AXI read response
- m_rlast  in  1  ignored (single beat)
- m_rvalid  in  1  AXI R valid
- m_rready  out  1  AXI R ready
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_pc  out  32  PC of head
- inst_bits  out  32  instruction word of head
- inst_fault  out  1  head carries bus error
- debug_last_pc  out  32  PC of last accepted instruction

Behaviour:
- Reset (ARESETN=0, async):
  - Registered outputs: m_arvalid=0, m_rready=0, inst_valid=0, debug_last_pc=0, m_araddr=0.
  - Internal state: FIFO empty, pc=0, discard=0, state=IDLE.
- States:
  - IDLE: no requests.
  - ADDR: m_arvalid=1.
  - DATA: m_rready=1, waiting for R.
  - HALT: fault seen.
- run rising edge (registered run_q=0, run=1): pc<=entry_pc, FIFO flushed.
- Issue condition (IDLE or after DATA completes):
  - Requires run=1, state not HALT, and fifo_count + 1 <= FIFO_DEPTH (at most one outstanding read).
  - Next cycle: m_arvalid=1 and m_araddr=dram_base+pc (mod 2^32). Address arithmetic is a 32-bit wrap; pc increments by 4 mod 2^32.
- ADDR:
  - m_arvalid and m_araddr hold stable until m_arready=1 (AXI rule, never withdrawn).
  - On handshake go to DATA.
- DATA:
  - On m_rvalid&m_rready, push {pc_req, rdata, rresp!=0} into the FIFO unless discard=1.
  - If not discarded: pc<=pc_req+4, then ADDR if the issue condition holds, else IDLE.
  - Back-to-back issue is allowed: a new AR may assert the cycle after R completes.
- Fault: a pushed entry with rresp!=OKAY sets inst_fault on that entry and enters HALT. Only redirect or run falling leaves HALT.
- Redirect (any state):
  - pc<=redirect_pc and the FIFO is flushed in the same cycle; a concurrent inst_ready pop is void.
  - If a transaction is outstanding (ADDR or DATA), discard<=1.
  - The discarded response is consumed (m_rready=1) and dropped; discard then clears and fetch resumes at redirect_pc.
  - HALT goes to IDLE/ADDR.
- run falls mid-transaction: the outstanding AR/R completes and its response is dropped. Then IDLE, FIFO flushed.
- Simultaneous R push and inst_ready pop with the FIFO full-minus-one: both occur; count unchanged.
- FIFO:
  - inst_* driven from the head register; zero-bubble when not empty.
  - Push-to-inst_valid latency is 1 cycle.
- debug_last_pc <= inst_pc on inst_valid&inst_ready.
- Expected latency: run rise to first m_arvalid is 2 cycles (edge detect + issue).

Test Plan:
1. dram_base=0x2000_0000, entry_pc=0, run=1, ARREADY always 1, R returns 1 cycle later, inst_ready=1.
   - m_araddr sequence 0x2000_0000, 0x2000_0004, 0x2000_0008…
   - inst_pc 0,4,8 with matching data.
   - debug_last_pc follows.
2. Random ARREADY/RVALID delays (0–7 cycles), 64 words.
   - Every word is delivered in order exactly once.
   - m_araddr never changes while m_arvalid=1 and m_arready=0.
3. inst_ready=0 with FIFO_DEPTH=4.
   - Exactly 4 reads are issued, then m_arvalid stays 0.
   - Raising inst_ready resumes fetch at pc=0x10.
4. Redirect to 0x100 while in DATA for pc=0x8.
   - The pc=0x8 response is dropped; FIFO empty the next cycle.
   - Next m_araddr=0x2000_0100; first delivered inst_pc=0x100.
5. RRESP=SLVERR on pc=0xC.
   - inst_pc=0xC is delivered with inst_fault=1; no further ARVALID.
   - A redirect to 0 restarts fetch at 0x2000_0000.
6. ARESETN pulse low mid-DATA, and separately entry_pc=0xFFFF_FFFC.
   - Reset: all outputs return to reset values immediately.
   - entry_pc case: second fetch wraps to pc=0, m_araddr=dram_base.
